// File: rtl/mem_arb_pkg.sv
// Shared size codes, FSM state encoding and alignment helper for mem_port_arbiter.
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_BUSY_IF = 2'b01,
        S_BUSY_D  = 2'b10,
        S_DONE    = 2'b11
    } state_e;

    // Size code 11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: byte enables, store data replication, load extract and extend.
module lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_data
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    // Halves use addr[1] only, words ignore the low bits: truncated alignment.
    assign b_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign h_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        ld_data   = rdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                ld_data   = {{24{~is_unsigned & b_sel[7]}}, b_sel};
            end
            SZ_HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                ld_data   = {{16{~is_unsigned & h_sel[15]}}, h_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with bounded data priority.
// Define MISALIGN_TRAP_EN to add the misalign output and trap misaligned data accesses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        stall
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam int FW = $clog2(FAIR_LIMIT + 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);

    state_e        state_q, state_d;
    logic [FW-1:0] fair_cnt;
    logic          grant_if, grant_d, trap, d_mis;
    logic          r_fetch, r_we, r_unsigned;
    logic [1:0]    r_size;
    logic [31:0]   r_addr, r_wdata;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata, ld_data;

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    assign d_mis    = is_misaligned(d_size, d_addr[1:0]);
    assign misalign = mis_q;
`else
    assign d_mis = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        trap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req && (!d_req || fair_cnt == FAIR_MAX)) begin
                    grant_if = 1'b1;
                    state_d  = S_BUSY_IF;
                end else if (d_req) begin
                    grant_d = 1'b1;
                    trap    = d_mis;
                    state_d = d_mis ? S_DONE : S_BUSY_D;
                end
            end
            S_BUSY_IF, S_BUSY_D: if (m_ready) state_d = S_DONE;
            S_DONE:              state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fair_cnt   <= '0;
            m_req      <= 1'b0;
            r_fetch    <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
`ifdef MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= trap;
`endif
            if (grant_if) begin
                fair_cnt   <= '0;
                r_fetch    <= 1'b1;
                r_we       <= 1'b0;
                r_size     <= SZ_WORD;
                r_unsigned <= 1'b0;
                r_addr     <= if_addr;
                r_wdata    <= '0;
                m_req      <= 1'b1;
            end
            if (grant_d) begin
                if (if_req && fair_cnt != FAIR_MAX) fair_cnt <= fair_cnt + 1'b1;
                r_fetch    <= 1'b0;
                r_we       <= d_we;
                r_size     <= d_size;
                r_unsigned <= d_unsigned;
                r_addr     <= d_addr;
                r_wdata    <= d_wdata;
                m_req      <= ~trap;
            end
            if (trap) begin
                d_ack   <= 1'b1;
                d_rdata <= '0;
            end
            // m_req is only ever high in the BUSY states, so m_ready is ignored elsewhere.
            if (m_req && m_ready) begin
                m_req <= 1'b0;
                if (r_fetch) begin
                    if_ack   <= 1'b1;
                    if_rdata <= m_rdata;
                end else begin
                    d_ack   <= 1'b1;
                    d_rdata <= r_we ? 32'h0 : ld_data;
                end
            end
        end
    end

    lane_align u_lane_align (
        .size        (r_size),
        .addr_lo     (r_addr[1:0]),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .rdata       (m_rdata),
        .be          (lane_be),
        .wdata_rep   (lane_wdata),
        .ld_data     (ld_data)
    );

    assign m_addr  = {r_addr[31:2], 2'b00};
    assign m_we    = m_req & r_we;
    assign m_be    = m_req ? lane_be : 4'h0;
    assign m_wdata = (m_req & r_we) ? lane_wdata : 32'h0;
    assign stall   = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int FL = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        if_req = 0, if_ack;
    logic [31:0] if_addr = 0, if_rdata;
    logic        d_req = 0, d_we = 0, d_unsigned = 0, d_ack;
    logic [1:0]  d_size = 0;
    logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
    logic        m_req, m_we, m_ready = 1'b1, stall;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata = 0;
    logic        misalign;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FAIR_LIMIT(FL)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .stall(stall)
`ifdef MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );
`ifndef MISALIGN_TRAP_EN
    assign misalign = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---- reference model, written from the access rules ----
    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] f_ld(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else v = rd;
        return v;
    endfunction

    function automatic bit f_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
`endif
        return 1'b0;
    endfunction

    // ---- per-cycle compare against the model ----
    int          mcnt = 0;
    bit          pend = 0, pend_f = 0, e_mis = 0, prev_if = 0, prev_d = 0;
    logic [31:0] e_addr, e_wd, e_rd, held_d = 0, held_if = 0;
    logic [3:0]  e_be;
    logic        e_we;

    always @(negedge clk) begin
        if (reset) begin
            mcnt = 0; pend = 0; held_d = 0; held_if = 0;
        end else begin
            check("stall", stall, (if_req & ~if_ack) | (d_req & ~d_ack));
            check("ack_exclusive", if_ack & d_ack, 0);
            if (!pend && (m_req || if_ack || d_ack)) begin
                pend   = 1;
                pend_f = prev_if && (!prev_d || mcnt == FL);
                if (pend_f) begin
                    mcnt = 0;
                    e_addr = (if_addr / 4) * 4; e_be = 4'hF; e_we = 0; e_wd = 0;
                    e_mis = 0; e_rd = m_rdata;
                end else begin
                    if (prev_if && mcnt < FL) mcnt++;
                    e_addr = (d_addr / 4) * 4; e_be = f_be(d_size, d_addr); e_we = d_we;
                    e_wd = f_wd(d_size, d_wdata); e_mis = f_mis(d_size, d_addr);
                    e_rd = (d_we || e_mis) ? 32'h0 : f_ld(d_size, d_unsigned, d_addr, m_rdata);
                end
            end
            if (pend && m_req) begin
                check("m_addr", m_addr, e_addr);
                check("m_be", m_be, e_be);
                check("m_we", m_we, e_we);
                if (e_we) check("m_wdata", m_wdata, e_wd);
                if (e_mis) check("trap_no_mreq", m_req, 0);
            end
            if (pend && (if_ack || d_ack)) begin
                check("ack_port_fetch", if_ack, pend_f);
                if (d_ack) begin check("d_rdata", d_rdata, e_rd); held_d = e_rd; end
                if (if_ack) begin check("if_rdata", if_rdata, e_rd); held_if = e_rd; end
                check("misalign", misalign, d_ack & e_mis);
                pend = 0;
            end else begin
                check("misalign_idle", misalign, 0);
            end
            if (!d_ack)  check("d_rdata_hold", d_rdata, held_d);
            if (!if_ack) check("if_rdata_hold", if_rdata, held_if);
        end
        prev_if = if_req; prev_d = d_req;
    end

    // ---- capture for hand-computed checks ----
    logic [31:0] cap_addr, cap_wd, cap_drd, cap_ifrd;
    logic [3:0]  cap_be;
    logic        cap_we, cap_mis;
    bit          saw_mreq;
    always @(negedge clk) begin
        if (m_req) begin
            cap_addr = m_addr; cap_be = m_be; cap_wd = m_wdata; cap_we = m_we; saw_mreq = 1;
        end
        if (d_ack) begin cap_drd = d_rdata; cap_mis = misalign; end
        if (if_ack) cap_ifrd = if_rdata;
    end

    task automatic data_txn(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        d_req = 1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
        m_rdata = rd; saw_mreq = 0; lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1; lat++;
            if (d_ack) break;
        end
        check("d_ack_timeout", d_ack, 1);
        @(posedge clk); #1; d_req = 0;
    endtask

    task automatic fetch_txn(input logic [31:0] a, input logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        if_req = 1; if_addr = a; m_rdata = rd; lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1; lat++;
            if (if_ack) break;
        end
        check("if_ack_timeout", if_ack, 1);
        @(posedge clk); #1; if_req = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        logic [3:0]  b_be;
        logic [31:0] b_addr;
        bit order [10];
        bit exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_req", m_req, 0);
        check("rst_m_be", m_be, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_acks", {if_ack, d_ack}, 0);
        check("rst_rdata", d_rdata | if_rdata, 0);
        reset = 0;

        // Idle: no requests, no bus activity
        repeat (4) begin
            @(negedge clk);
            check("idle_quiet", {m_req, if_ack, d_ack}, 0);
        end

        // Fairness with both requesters held
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h1000; m_rdata = 32'hCAFE_0001;
        d_req = 1; d_we = 0; d_size = 2'b10; d_unsigned = 0; d_addr = 32'h40;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(posedge clk); #1;
            if (d_ack) begin order[n] = 0; n++; end
            else if (if_ack) begin order[n] = 1; n++; end
        end
        check("fair_ack_count", n, 10);
        @(posedge clk); #1; if_req = 0; d_req = 0;
        for (int i = 0; i < 10; i++) check($sformatf("fair_order%0d", i), order[i], exp_order[i]);

        // lb 0x103
        data_txn(0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF_FF00, lat);
        check("lb_be", cap_be, 4'b1000);
        check("lb_rdata", cap_drd, 32'hFFFF_FF80);
        check("lb_ack_cycle", lat, 2);   // grant, busy, ack cycles

        // sh 0x22
        data_txn(1, 2'b01, 0, 32'h22, 32'h0000_BEEF, 32'h1234_5678, lat);
        check("sh_addr", cap_addr, 32'h20);
        check("sh_be", cap_be, 4'b1100);
        check("sh_wdata", cap_wd, 32'hBEEF_BEEF);
        check("sh_we", cap_we, 1);
        check("sh_rdata", cap_drd, 0);

        data_txn(0, 2'b00, 1, 32'h101, 32'h0, 32'h1234_A5B6, lat);
        check("lbu_rdata", cap_drd, 32'h0000_00A5);
        data_txn(0, 2'b01, 0, 32'h2, 32'h0, 32'h8001_7FFF, lat);
        check("lh_rdata", cap_drd, 32'hFFFF_8001);
        data_txn(0, 2'b01, 1, 32'h0, 32'h0, 32'h8001_F00D, lat);
        check("lhu_rdata", cap_drd, 32'h0000_F00D);
        data_txn(1, 2'b00, 0, 32'h41, 32'h1234_5678, 32'h0, lat);
        check("sb_be", cap_be, 4'b0010);
        check("sb_wdata", cap_wd, 32'h7878_7878);
        data_txn(1, 2'b10, 0, 32'h50, 32'hDEAD_BEEF, 32'h0, lat);
        check("sw_wdata", cap_wd, 32'hDEAD_BEEF);
        data_txn(0, 2'b11, 0, 32'h8, 32'h0, 32'h1122_3344, lat);
        check("size11_be", cap_be, 4'hF);
        check("size11_rdata", cap_drd, 32'h1122_3344);

        // Misaligned lw 0x06
        data_txn(0, 2'b10, 0, 32'h06, 32'h0, 32'hA5A5_5A5A, lat);
`ifdef MISALIGN_TRAP_EN
        check("mis_flag", cap_mis, 1);
        check("mis_no_mreq", saw_mreq, 0);
        check("mis_rdata", cap_drd, 0);
        check("mis_ack_cycle", lat, 1);
`else
        check("mis_addr", cap_addr, 32'h04);
        check("mis_be", cap_be, 4'hF);
        check("mis_rdata", cap_drd, 32'hA5A5_5A5A);
`endif

        fetch_txn(32'h207, 32'h55AA_55AA, lat);
        check("if_addr", cap_addr, 32'h204);
        check("if_be_we", {cap_be, cap_we}, 5'b11110);
        check("if_rdata_val", cap_ifrd, 32'h55AA_55AA);

        // Memory wait states
        @(posedge clk); #1;
        m_ready = 0; d_req = 1; d_we = 1; d_size = 2'b01; d_addr = 32'h36; d_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        b_be = m_be; b_addr = m_addr;
        check("wait_be", b_be, 4'b1100);
        repeat (10) begin
            @(negedge clk);
            check("wait_mreq", m_req, 1);
            check("wait_stall", stall, 1);
            check("wait_noack", d_ack, 0);
            check("wait_stable", {m_be, m_addr, m_wdata}, {b_be, b_addr, 32'h1234_1234});
        end
        @(posedge clk); #1; m_ready = 1;
        @(posedge clk); #1;
        check("wait_ack_next", d_ack, 1);
        @(posedge clk); #1; d_req = 0;

        // Reset in BUSY_D, late m_ready
        @(posedge clk); #1;
        m_ready = 0; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h30; m_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("rst_busy_mreq", m_req, 1);
        reset = 1;
        @(posedge clk); #1;
        check("rst_drop_mreq", m_req, 0);
        reset = 0; d_req = 0; m_ready = 1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_no_ack", {d_ack, if_ack, m_req}, 0);
            check("rst_outs", {m_be, m_we, m_addr, m_wdata}, 0);
            check("rst_rd", d_rdata | if_rdata, 0);
        end
        data_txn(0, 2'b10, 0, 32'h44, 32'h0, 32'h0BAD_F00D, lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_rdata", cap_drd, 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter FAIR_LIMIT, default 4: the maximum number of consecutive data grants while a fetch is pending.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have fetch ports if_req in 1, if_addr in 32, if_rdata out 32 and if_ack out 1.
REQ-005 SHALL have data ports d_req in 1, d_we in 1, d_size in 2 (00 byte, 01 half, 10 word), d_unsigned in 1, d_addr in 32, d_wdata in 32, d_rdata out 32 and d_ack out 1.
REQ-006 SHALL have memory ports m_req out 1, m_we out 1, m_be out 4, m_addr out 32, m_wdata out 32, m_rdata in 32 and m_ready in 1.
REQ-007 SHALL have port stall, out, 1: pipeline hold; it also has port misalign, out, 1, which exists only when MISALIGN_TRAP_EN is defined.

Function
REQ-008 SHALL implement FSM IDLE -> BUSY_IF | BUSY_D -> DONE -> IDLE.
REQ-009 SHALL sample requests only in IDLE: d_req wins unless if_req is pending and fair_cnt==FAIR_LIMIT, in which case the fetch is granted.
REQ-010 SHALL increment fair_cnt on a data grant made while if_req=1, saturating at FAIR_LIMIT, and clear it on any fetch grant.
REQ-011 SHALL register the granted request at the grant edge and drive m_req=1 from the next cycle until m_ready=1 is sampled; m_addr/m_we/m_be/m_wdata SHALL stay stable while m_req=1.
REQ-012 SHALL drive m_addr={addr[31:2],2'b00}.
REQ-013 SHALL drive fetch accesses as a word read with m_be=4'b1111 and m_we=0.
REQ-014 SHALL generate byte enables: byte = 1<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
REQ-015 SHALL replicate store data across lanes: a byte write gives {4{b}} and a half write gives {2{h}}.
REQ-016 SHALL register m_rdata on the m_ready cycle.
REQ-017 SHALL, in DONE, pulse the granted requester's ack for exactly one cycle with its rdata valid in that cycle.
REQ-018 SHALL hold d_rdata and if_rdata until the next ack of the same port.
REQ-019 SHALL form load data by shifting right by addr[1:0]*8 and then sign-extending, or zero-extending when d_unsigned=1, to 32 bits.
REQ-020 SHALL return d_rdata=0 for stores.
REQ-021 SHALL ignore all requests in DONE; requesters change or drop req on the cycle after ack.
REQ-022 SHALL give a fetch-to-data or data-to-fetch turnaround of one IDLE cycle minimum, i.e. a 3-cycle best case from grant to ack with m_ready tied high.
REQ-023 SHALL make stall combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-024 SHALL ignore m_ready when m_req=0.
REQ-025 SHALL treat d_size=11 as word.
REQ-026 SHALL perform no bus activity and hold both acks low when both requests are low in IDLE.

Reset
REQ-027 SHALL on reset set the FSM to IDLE and clear fair_cnt, m_req, m_we, m_be, m_addr, m_wdata, if_ack, d_ack, if_rdata, d_rdata and misalign to 0.
REQ-028 SHALL, on reset mid-transaction, abandon the transaction: m_req drops at the reset edge, no ack is issued, and a late m_ready is ignored.

Configuration
REQ-029 SHALL, with MISALIGN_TRAP_EN defined, detect half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 at grant; these go straight to DONE with no m_req, d_ack=1, misalign=1 for one cycle and d_rdata=0.
REQ-030 SHALL, without MISALIGN_TRAP_EN, omit the misalign port and perform misaligned accesses at the truncated alignment (half uses addr[1]; word ignores addr[1:0]).

Structure
REQ-031 SHALL place the size codes BYTE/HALF/WORD (00/01/10) and the FSM state encoding in shared package mem_arb_pkg.
REQ-032 SHALL put byte-enable, store-replication and load-extract/extend logic in combinational sub-module lane_align, instantiated once.

Verification
REQ-033 SHALL check: lb, addr=0x103, m_rdata=0x80FF_FF00, m_ready tied 1 -> m_be=1000, d_rdata=0xFFFF_FF80, d_ack pulses on 3rd cycle after grant.
REQ-034 SHALL check: sh, addr=0x22, wdata=0x0000_BEEF -> m_addr=0x20, m_be=1100, m_wdata=0xBEEF_BEEF, m_we=1, d_ack with d_rdata=0.
REQ-035 SHALL check: if_req and d_req held continuously with FAIR_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-036 SHALL check: m_ready held 0 for 10 cycles -> m_req and bus fields stable, stall=1, no ack; m_ready=1 -> ack the next cycle.
REQ-037 SHALL check: reset asserted in BUSY_D, then m_ready=1 after release -> no d_ack, FSM in IDLE, all outputs 0.
REQ-038 SHALL check: lw, addr=0x06 -> with MISALIGN_TRAP_EN: misalign=1, d_ack=1, no m_req; without: m_addr=0x04, m_be=1111.
